// File: rtl/rtc_clock_core_pkg.sv
// Shared encodings and field arithmetic for the time-of-day clock core.
package rtc_clock_pkg;

  typedef enum logic {
    ST_SET = 1'b0,
    ST_RUN = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    F_HOUR    = 3'd0,
    F_MIN     = 3'd1,
    F_SEC     = 3'd2,
    F_AL_HOUR = 3'd3,
    F_AL_MIN  = 3'd4
  } field_e;

  localparam logic [3:0] SEP_NIBBLE = 4'hA;
  localparam logic [5:0] SEC_MOD    = 6'd60;
  localparam logic [5:0] MIN_MOD    = 6'd60;

  // One step up or down inside 0..m-1, wrapping at either end.
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] m,
                                           input logic up);
    if (up) return (v == m - 6'd1) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? m - 6'd1 : v - 6'd1;
  endfunction

endpackage

// File: rtl/rtc_clock_core_if.sv
// Key pulses in, display/status out. RTC_CLOCK_ALARM_EN adds alarm_en/alarm.
interface rtc_clock_core_if;
  logic        mode_key;
  logic        sel_key;
  logic        inc_key;
  logic        dec_key;
  logic        run;
  logic [2:0]  sel;
  logic        sec_tick;
  logic [31:0] dout;
`ifdef RTC_CLOCK_ALARM_EN
  logic        alarm_en;
  logic        alarm;

  modport master (output mode_key, sel_key, inc_key, dec_key, alarm_en,
                  input  run, sel, sec_tick, dout, alarm);
  modport slave  (input  mode_key, sel_key, inc_key, dec_key, alarm_en,
                  output run, sel, sec_tick, dout, alarm);
`else
  modport master (output mode_key, sel_key, inc_key, dec_key,
                  input  run, sel, sec_tick, dout);
  modport slave  (input  mode_key, sel_key, inc_key, dec_key,
                  output run, sel, sec_tick, dout);
`endif
endinterface

// File: rtl/rtc_clock_core_bin2bcd.sv
// Combinational 0..99 binary to two packed BCD digits.
module bin2bcd_2dig (
  input  logic [6:0] bin_i,
  output logic [7:0] bcd_o
);
  logic [3:0] tens;
  logic [6:0] rem;

  always_comb begin
    tens = 4'd0;
    rem  = bin_i;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    bcd_o = {tens, 4'(rem)};
  end
endmodule

// File: rtl/rtc_clock_core.sv
// Time-of-day clock core: SET/RUN modes, per-field edit, prescaled 1 Hz tick.
// Optional alarm registers/ports under RTC_CLOCK_ALARM_EN.
module rtc_clock_core
  import rtc_clock_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int PRE_W    = 26,
  parameter int HOUR_MOD = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  rtc_clock_core_if.slave  bus
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);
  localparam logic [5:0]       HR_MOD  = 6'(HOUR_MOD);
`ifdef RTC_CLOCK_ALARM_EN
  localparam logic [2:0]       SEL_LAST = 3'd4;
`else
  localparam logic [2:0]       SEL_LAST = 3'd2;
`endif

  state_e           state_q;
  logic [PRE_W-1:0] pre_q;
  logic [5:0]       hour_q, min_q, sec_q;
  logic [2:0]       sel_q;
  logic             tick_q;
  logic [31:0]      dout_q, dout_d;
  logic [7:0]       hour_bcd, min_bcd, sec_bcd;

  logic             wrap, sec_cy, min_cy, step, up;
  logic [5:0]       hour_c, min_c, sec_c;

  // Carry chain for a seconds increment; hour wraps without further carry.
  always_comb begin
    wrap   = (pre_q == PRE_MAX);
    sec_c  = wrap_step(sec_q, SEC_MOD, 1'b1);
    sec_cy = (sec_q == SEC_MOD - 6'd1);
    min_c  = sec_cy ? wrap_step(min_q, MIN_MOD, 1'b1) : min_q;
    min_cy = sec_cy && (min_q == MIN_MOD - 6'd1);
    hour_c = min_cy ? wrap_step(hour_q, HR_MOD, 1'b1) : hour_q;
    step   = bus.inc_key ^ bus.dec_key;
    up     = bus.inc_key;
    dout_d = {hour_bcd, SEP_NIBBLE, min_bcd, SEP_NIBBLE, sec_bcd};
  end

  bin2bcd_2dig u_hour (.bin_i({1'b0, hour_q}), .bcd_o(hour_bcd));
  bin2bcd_2dig u_min  (.bin_i({1'b0, min_q}),  .bcd_o(min_bcd));
  bin2bcd_2dig u_sec  (.bin_i({1'b0, sec_q}),  .bcd_o(sec_bcd));

`ifdef RTC_CLOCK_ALARM_EN
  logic [5:0] al_hour_q, al_min_q;
  logic       alarm_q;
  logic       any_key;

  assign any_key = bus.mode_key | bus.sel_key | bus.inc_key | bus.dec_key;

  // Clear wins over set; set only on the tick landing exactly on hh:mm:00.
  always_ff @(posedge clk) begin
    if (!rst_n)                          alarm_q <= 1'b0;
    else if (any_key || !bus.alarm_en)   alarm_q <= 1'b0;
    else if (state_q == ST_RUN && wrap && hour_c == al_hour_q &&
             min_c == al_min_q && sec_c == 6'd0)
                                         alarm_q <= 1'b1;
  end

  assign bus.alarm = alarm_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_SET;
      pre_q   <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      sel_q   <= '0;
      tick_q  <= 1'b0;
      dout_q  <= {8'h00, SEP_NIBBLE, 8'h00, SEP_NIBBLE, 8'h00};
`ifdef RTC_CLOCK_ALARM_EN
      al_hour_q <= '0;
      al_min_q  <= '0;
`endif
    end else begin
      tick_q <= 1'b0;
      dout_q <= dout_d;
      if (bus.mode_key) begin
        // Leaving RUN drops any partial second; entering RUN starts from 0.
        state_q <= (state_q == ST_SET) ? ST_RUN : ST_SET;
        pre_q   <= '0;
      end else if (state_q == ST_RUN) begin
        if (wrap) begin
          pre_q  <= '0;
          tick_q <= 1'b1;
          sec_q  <= sec_c;
          min_q  <= min_c;
          hour_q <= hour_c;
        end else begin
          pre_q <= pre_q + PRE_W'(1);
        end
      end else begin
        pre_q <= '0;
        if (bus.sel_key) sel_q <= (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
        if (step) begin
          case (field_e'(sel_q))
            F_HOUR:    hour_q    <= wrap_step(hour_q, HR_MOD, up);
            F_MIN:     min_q     <= wrap_step(min_q, MIN_MOD, up);
            F_SEC:     sec_q     <= wrap_step(sec_q, SEC_MOD, up);
`ifdef RTC_CLOCK_ALARM_EN
            F_AL_HOUR: al_hour_q <= wrap_step(al_hour_q, HR_MOD, up);
            F_AL_MIN:  al_min_q  <= wrap_step(al_min_q, MIN_MOD, up);
`endif
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.run      = (state_q == ST_RUN);
  assign bus.sel      = sel_q;
  assign bus.sec_tick = tick_q;
  assign bus.dout     = dout_q;

endmodule

// File: tb/tb_rtc_clock_core.sv
// Directed bench for rtc_clock_core at CLK_HZ=10, 24 h and 12 h instances.
module tb_rtc_clock_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass = 0;
  int   total = 0;
  int   ticks = 0;

  always #5 clk = ~clk;

  rtc_clock_core_if b24();
  rtc_clock_core_if b12();

  rtc_clock_core #(.CLK_HZ(10), .PRE_W(4), .HOUR_MOD(24)) u24 (.clk(clk), .rst_n(rst_n), .bus(b24));
  rtc_clock_core #(.CLK_HZ(10), .PRE_W(4), .HOUR_MOD(12)) u12 (.clk(clk), .rst_n(rst_n), .bus(b12));

  always @(negedge clk) if (b24.sec_tick === 1'b1) ticks++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic k24(input logic m, input logic s, input logic i, input logic d);
    b24.mode_key = m; b24.sel_key = s; b24.inc_key = i; b24.dec_key = d;
    cyc(1);
    b24.mode_key = 0; b24.sel_key = 0; b24.inc_key = 0; b24.dec_key = 0;
  endtask

  task automatic k12(input logic m, input logic s, input logic i, input logic d);
    b12.mode_key = m; b12.sel_key = s; b12.inc_key = i; b12.dec_key = d;
    cyc(1);
    b12.mode_key = 0; b12.sel_key = 0; b12.inc_key = 0; b12.dec_key = 0;
  endtask

  initial begin
    b24.mode_key = 0; b24.sel_key = 0; b24.inc_key = 0; b24.dec_key = 0;
    b12.mode_key = 0; b12.sel_key = 0; b12.inc_key = 0; b12.dec_key = 0;
`ifdef RTC_CLOCK_ALARM_EN
    b24.alarm_en = 0; b12.alarm_en = 0;
`endif
    // Reset
    cyc(2);
    rst_n = 1'b1;
    chk("rst_dout", b24.dout, 32'h00A00A00);
    chk("rst_run", {31'd0, b24.run}, 32'd0);
    chk("rst_sel", {29'd0, b24.sel}, 32'd0);
    chk("rst_tick", {31'd0, b24.sec_tick}, 32'd0);
    cyc(1);
    chk("rst_dout_hold", b24.dout, 32'h00A00A00);
    chk("rst_dout12", b12.dout, 32'h00A00A00);
`ifdef RTC_CLOCK_ALARM_EN
    chk("rst_alarm", {31'd0, b24.alarm}, 32'd0);
`endif

    // Hour edit wraps both ways
    k24(0, 0, 0, 1); cyc(1);
    chk("hour_dec_wrap", b24.dout, 32'h23A00A00);
    k24(0, 0, 1, 0); cyc(1);
    chk("hour_inc_wrap", b24.dout, 32'h00A00A00);
    k12(0, 0, 0, 1); cyc(1);
    chk("hour12_dec_wrap", b12.dout, 32'h11A00A00);
    k12(0, 0, 1, 0); cyc(1);
    chk("hour12_inc_wrap", b12.dout, 32'h00A00A00);

    // Seconds edit: wrap without carry, inc+dec together is a no-op
    k24(0, 1, 0, 0); k24(0, 1, 0, 0);
    chk("sel_sec", {29'd0, b24.sel}, 32'd2);
    k24(0, 0, 0, 1); cyc(1);
    chk("sec_dec_wrap", b24.dout, 32'h00A00A59);
    k24(0, 0, 1, 0); cyc(1);
    chk("sec_inc_nocarry", b24.dout, 32'h00A00A00);
    k24(0, 0, 1, 0); cyc(1);
    chk("sec_inc", b24.dout, 32'h00A00A01);
    k24(0, 0, 1, 1); cyc(1);
    chk("inc_dec_noop", b24.dout, 32'h00A00A01);
    k24(0, 1, 0, 0);
`ifdef RTC_CLOCK_ALARM_EN
    chk("sel_wrap", {29'd0, b24.sel}, 32'd3);
    k24(0, 1, 0, 0); k24(0, 1, 0, 0);
`else
    chk("sel_wrap", {29'd0, b24.sel}, 32'd0);
`endif

    // Set 23:59:58 and run across midnight
    k24(0, 0, 0, 1);
    k24(0, 1, 0, 0); k24(0, 0, 0, 1);
    k24(0, 1, 0, 0); k24(0, 0, 0, 1); k24(0, 0, 0, 1); k24(0, 0, 0, 1);
    cyc(1);
    chk("preset", b24.dout, 32'h23A59A58);
    ticks = 0;
    k24(1, 0, 0, 0);
    chk("run_on", {31'd0, b24.run}, 32'd1);
    cyc(9);
    chk("no_early_tick", {31'd0, b24.sec_tick}, 32'd0);
    cyc(1);
    chk("tick1", {31'd0, b24.sec_tick}, 32'd1);
    cyc(1);
    chk("t_235959", b24.dout, 32'h23A59A59);
    cyc(9);
    chk("tick2", {31'd0, b24.sec_tick}, 32'd1);
    cyc(1);
    chk("midnight", b24.dout, 32'h00A00A00);
    chk("tick_count", ticks, 32'd2);

    // Mode beats inc at prescaler=5; partial second discarded
    cyc(4);
    k24(1, 0, 1, 0);
    chk("mode_prio_run", {31'd0, b24.run}, 32'd0);
    cyc(1);
    chk("mode_prio_fields", b24.dout, 32'h00A00A00);
    chk("no_extra_tick", ticks, 32'd2);
    ticks = 0;
    k24(1, 0, 0, 0);
    cyc(9);
    chk("reenter_no_tick", ticks, 32'd0);
    cyc(1);
    chk("reenter_tick", {31'd0, b24.sec_tick}, 32'd1);
    cyc(1);
    chk("reenter_sec", b24.dout, 32'h00A00A01);

    // Reset mid-RUN with pending keys
    cyc(3);
    rst_n = 1'b0;
    b24.mode_key = 1; b24.inc_key = 1;
    cyc(1);
    rst_n = 1'b1;
    b24.mode_key = 0; b24.inc_key = 0;
    chk("mrst_run", {31'd0, b24.run}, 32'd0);
    chk("mrst_sel", {29'd0, b24.sel}, 32'd0);
    chk("mrst_dout", b24.dout, 32'h00A00A00);
    chk("mrst_tick", {31'd0, b24.sec_tick}, 32'd0);
    ticks = 0;
    cyc(12);
    chk("mrst_stays_set", ticks, 32'd0);
    chk("mrst_dout_hold", b24.dout, 32'h00A00A00);

`ifdef RTC_CLOCK_ALARM_EN
    // Alarm 00:01, time 00:00:59
    repeat (4) k24(0, 1, 0, 0);
    k24(0, 0, 1, 0);
    repeat (3) k24(0, 1, 0, 0);
    k24(0, 0, 0, 1);
    b24.alarm_en = 1;
    k24(1, 0, 0, 0);
    cyc(9);
    chk("alarm_pre", {31'd0, b24.alarm}, 32'd0);
    cyc(1);
    chk("alarm_set", {31'd0, b24.alarm}, 32'd1);
    cyc(2);
    chk("alarm_hold", {31'd0, b24.alarm}, 32'd1);
    k24(0, 1, 0, 0);
    chk("alarm_clr", {31'd0, b24.alarm}, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/rtc_clock_core.md
Name: rtc_clock_core

Overview:
- Parametrised time-of-day clock core with a set/run mode.
- Per-field increment/decrement and a prescaled 1 Hz tick.
- Registered packed-BCD display word.
- Sits between the key debounce/pulse logic and the 7-segment scan driver; successor to the fixed 50 MHz, 24 h, increment-only clock.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency; the prescaler wraps at CLK_HZ-1.
- PRE_W, 26, prescaler width; must satisfy 2^PRE_W >= CLK_HZ.
- HOUR_MOD, 24, hour modulus; legal values 24 or 12. For 12, hours run 0..11.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low; sampled on rising clk edge only
- mode_key  in  1  one-cycle pulse; toggles SET/RUN
- sel_key  in  1  one-cycle pulse; advances the selected field (SET only)
- inc_key  in  1  one-cycle pulse; selected field +1 (SET only)
- dec_key  in  1  one-cycle pulse; selected field -1 (SET only)
- run  out  1  1 in RUN, 0 in SET
- sel  out  3  selected field: 0=HOUR, 1=MIN, 2=SEC (3,4 only with alarm)
- sec_tick  out  1  one-cycle pulse on each seconds increment in RUN
- dout  out  32  {hour_bcd[7:0], 4'hA, min_bcd[7:0], 4'hA, sec_bcd[7:0]}

Behaviour:
- Reset (rst_n=0 at a clk edge), next cycle:
  - state=SET, prescaler=0, hour=min=sec=0, sel=0, run=0, sec_tick=0
  - dout=32'h00A00A00
- States: SET, RUN.
  - mode_key toggles state; it has priority over inc/dec/sel in the same cycle, which are then ignored.
- RUN:
  - Prescaler counts every cycle. At CLK_HZ-1 it wraps to 0, sec_tick=1 for that cycle, and sec increments.
  - Carry chain: sec 59->0 carries to min; min 59->0 carries to hour; hour HOUR_MOD-1 -> 0, with no further carry.
  - sel/inc/dec ignored.
- SET:
  - Prescaler held at 0, so the first tick after entering RUN occurs exactly CLK_HZ cycles later.
  - sel_key: sel advances modulo the field count.
  - inc_key/dec_key: modify only the selected field, wrapping within that field's range (sec/min 0..59, hour 0..HOUR_MOD-1), with no carry into other fields.
  - inc_key and dec_key in the same cycle: no change.
- dout is registered: it reflects the binary fields one cycle after they change. Binary-to-BCD conversion is per field, with a range of 0..59.
- Switching from RUN to SET mid-second discards the partial prescaler count.
- Reset mid-operation overrides everything, including pending key pulses.

Optional Feature:
- Macro: RTC_CLOCK_ALARM_EN.
- Defined:
  - Adds registers al_hour and al_min (reset 0).
  - sel cycles 0..4; 3=AL_HOUR, 4=AL_MIN, edited with the same inc/dec rules.
  - Adds ports: alarm_en (in, 1) and alarm (out, 1, reset 0).
  - alarm sets on the sec_tick that makes the time equal al_hour:al_min:00 while alarm_en=1.
  - alarm holds until any key pulse or alarm_en=0. Clear has priority over set in the same cycle.
- Undefined: sel cycles 0..2, and no alarm registers or ports exist.

Decomposition:
- Package rtc_clock_pkg:
  - state encoding (SET, RUN)
  - field select codes (HOUR, MIN, SEC, AL_HOUR, AL_MIN)
  - SEP_NIBBLE=4'hA
  - SEC_MOD=60, MIN_MOD=60
- Sub-module bin2bcd_2dig: 7-bit binary (0..99) to two BCD digits, combinational. Instantiated three times, with outputs registered in the core.

Test Plan (CLK_HZ=10):
1. Reset: rst_n=0 for 2 cycles, then release -> dout=32'h00A00A00, run=0, sel=0, sec_tick=0.
2. SET, sel=HOUR:
   - dec_key -> dout=32'h23A00A00 one cycle later
   - then inc_key -> 32'h00A00A00
   - with HOUR_MOD=12, dec from 0 -> hour 11
3. SET sec to 59, inc_key -> sec=00, min unchanged (no carry). Pulse inc_key and dec_key together -> no change.
4. Set 23:59:58, pulse mode_key:
   - after 10 cycles -> 23:59:59, one sec_tick
   - after 20 cycles -> dout=32'h00A00A00
   - exactly 2 sec_ticks in total
5. In RUN at prescaler=5, pulse mode_key and inc_key together -> run=0, fields unchanged. Re-enter RUN -> first sec_tick 10 cycles later. Drive rst_n=0 one edge mid-RUN -> full reset values next cycle.
6. (RTC_CLOCK_ALARM_EN) Set alarm 00:01, time 00:00:59, alarm_en=1, RUN -> alarm=1 on the tick to 00:01:00; sel_key pulse -> alarm=0 next cycle.
